// File: rtl/or1200_qmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// or1200_qmem_arbiter_if
//   Bundles the instruction QMEM port, the data QMEM port and the shared
//   memory port that or1200_qmem_arbiter sits between.
//   slave  : arbiter view (takes CPU requests, drives the shared memory port)
//   master : environment view (CPU wrapper + on-chip RAM/ROM, or a testbench)
//   Signals:
//     icpu_cs/icpu_adr -> icpu_dat_r/icpu_ack          instruction port
//     dcpu_cs/we/sel/adr/dat_w -> dcpu_dat_r/dcpu_ack  data port
//     mem_cs/we/sel/adr/dat_w -> mem_dat_r/mem_ack     shared memory port
// ----------------------------------------------------------------------------
interface or1200_qmem_arbiter_if #(
  parameter int unsigned AW = 24
);
  logic          icpu_cs;
  logic [AW-1:0] icpu_adr;
  logic [31:0]   icpu_dat_r;
  logic          icpu_ack;

  logic          dcpu_cs;
  logic          dcpu_we;
  logic [3:0]    dcpu_sel;
  logic [AW-1:0] dcpu_adr;
  logic [31:0]   dcpu_dat_w;
  logic [31:0]   dcpu_dat_r;
  logic          dcpu_ack;

  logic          mem_cs;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_dat_w;
  logic [31:0]   mem_dat_r;
  logic          mem_ack;

  modport slave (
    input  icpu_cs, icpu_adr,
    output icpu_dat_r, icpu_ack,
    input  dcpu_cs, dcpu_we, dcpu_sel, dcpu_adr, dcpu_dat_w,
    output dcpu_dat_r, dcpu_ack,
    output mem_cs, mem_we, mem_sel, mem_adr, mem_dat_w,
    input  mem_dat_r, mem_ack
  );

  modport master (
    output icpu_cs, icpu_adr,
    input  icpu_dat_r, icpu_ack,
    output dcpu_cs, dcpu_we, dcpu_sel, dcpu_adr, dcpu_dat_w,
    input  dcpu_dat_r, dcpu_ack,
    input  mem_cs, mem_we, mem_sel, mem_adr, mem_dat_w,
    output mem_dat_r, mem_ack
  );
endinterface

// File: rtl/or1200_qmem_arbiter.sv
// ----------------------------------------------------------------------------
// or1200_qmem_arbiter
//   Shares one single-ported QMEM-style memory between the OR1200 instruction
//   and data QMEM ports. The grant is parked on the last owner; on contention
//   the two ports alternate one access each. A watchdog forces an ack (with
//   zero read data) when the memory fails to answer within TIMEOUT cycles and
//   raises the sticky err_timeout flag.
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     bus         instruction/data/memory ports (slave modport)
//     err_clr     clears err_timeout (a simultaneous new timeout wins)
//     err_timeout sticky timeout indication
//   Parameters:
//     AW          address width
//     TIMEOUT     cycles without mem_ack before a forced ack; 0 disables; max 255
// ----------------------------------------------------------------------------
module or1200_qmem_arbiter #(
  parameter int unsigned AW      = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  or1200_qmem_arbiter_if.slave   bus,
  input  logic                   err_clr,
  output logic                   err_timeout
);

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } state_t;

  // Watchdog value at which the pending access is given up.
  localparam logic [7:0] WDOG_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam logic       WDOG_EN   = (TIMEOUT != 0);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    wdog;

  logic          cs_mux;
  logic          we_mux;
  logic [3:0]    sel_mux;
  logic [AW-1:0] adr_mux;
  logic [31:0]   datw_mux;
  logic          forced;
  logic          granted_ack;

  // Shared port is a pure combinational mux of the granted CPU port, so a
  // parked owner reaches memory in the same cycle it raises cs.
  always_comb begin
    cs_mux   = 1'b0;
    we_mux   = 1'b0;
    sel_mux  = 4'hF;
    adr_mux  = '0;
    datw_mux = '0;
    unique case (state)
      GNT_I: begin
        cs_mux   = bus.icpu_cs;
        we_mux   = 1'b0;
        sel_mux  = 4'hF;
        adr_mux  = bus.icpu_adr;
        datw_mux = '0;
      end
      GNT_D: begin
        cs_mux   = bus.dcpu_cs;
        we_mux   = bus.dcpu_we;
        sel_mux  = bus.dcpu_sel;
        adr_mux  = bus.dcpu_adr;
        datw_mux = bus.dcpu_dat_w;
      end
      default: ;
    endcase
    // Reset must silence the memory immediately, not at the next edge.
    if (!rst_n) cs_mux = 1'b0;
  end

  assign bus.mem_cs    = cs_mux;
  assign bus.mem_we    = we_mux;
  assign bus.mem_sel   = sel_mux;
  assign bus.mem_adr   = adr_mux;
  assign bus.mem_dat_w = datw_mux;

  assign forced      = WDOG_EN && cs_mux && !bus.mem_ack && (wdog == WDOG_LAST);
  assign granted_ack = (bus.mem_ack && cs_mux) || forced;

  // Acks and read data back to the CPU ports; a forced ack returns zero data
  // on the granted port only.
  always_comb begin
    bus.icpu_ack   = 1'b0;
    bus.dcpu_ack   = 1'b0;
    bus.icpu_dat_r = bus.mem_dat_r;
    bus.dcpu_dat_r = bus.mem_dat_r;
    if (state == GNT_I) begin
      bus.icpu_ack = granted_ack;
      if (forced) bus.icpu_dat_r = '0;
    end else begin
      bus.dcpu_ack = granted_ack;
      if (forced) bus.dcpu_dat_r = '0;
    end
  end

  // Hand over only when the current access finishes (ack) or the owner is
  // idle; an owner with a pending access keeps the grant whatever the other
  // port does. Handing over on ack gives strict alternation under contention.
  always_comb begin
    state_nxt = state;
    unique case (state)
      GNT_I: if (bus.dcpu_cs && (granted_ack || !bus.icpu_cs)) state_nxt = GNT_D;
      GNT_D: if (bus.icpu_cs && (granted_ack || !bus.dcpu_cs)) state_nxt = GNT_I;
      default: state_nxt = GNT_I;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GNT_I;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wdog <= '0;
    else if (!cs_mux || bus.mem_ack) wdog <= '0;
    else if (forced)                 wdog <= '0;
    else                             wdog <= wdog + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_timeout <= 1'b0;
    else if (forced)  err_timeout <= 1'b1;
    else if (err_clr) err_timeout <= 1'b0;
  end

endmodule

// File: tb/tb_or1200_qmem_arbiter.sv
module tb_or1200_qmem_arbiter;

  logic clk;
  logic rst_n;
  logic err_clr;
  logic err_timeout;

  or1200_qmem_arbiter_if #(.AW(24)) bus ();

  or1200_qmem_arbiter #(.AW(24), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic        ics;
    logic [23:0] iadr;
    logic        dcs;
    logic        dwe;
    logic [3:0]  dsel;
    logic [23:0] dadr;
    logic [31:0] ddat;
    logic [31:0] mdat;
    logic        mack;
    logic        clr;
    // expected
    logic        e_cs;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [23:0] e_adr;
    logic [31:0] e_datw;
    logic        e_iack;
    logic        e_dack;
    logic [31:0] e_idat;
    logic [31:0] e_ddat;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.icpu_cs    = v.ics;
    bus.icpu_adr   = v.iadr;
    bus.dcpu_cs    = v.dcs;
    bus.dcpu_we    = v.dwe;
    bus.dcpu_sel   = v.dsel;
    bus.dcpu_adr   = v.dadr;
    bus.dcpu_dat_w = v.ddat;
    bus.mem_dat_r  = v.mdat;
    bus.mem_ack    = v.mack;
    err_clr        = v.clr;
  endtask

  initial begin
    // idle / parked on I
    vq.push_back(vec_t'{1'b0,24'h000000,1'b0,1'b0,4'h0,24'h000000,32'h0,32'h0,1'b0,1'b0,
                        1'b0,1'b0,4'hF,24'h000000,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0});
    // instruction read, ack same cycle
    vq.push_back(vec_t'{1'b1,24'h000100,1'b0,1'b0,4'h0,24'h000000,32'h0,32'h12345678,1'b1,1'b0,
                        1'b1,1'b0,4'hF,24'h000100,32'h0,1'b1,1'b0,32'h12345678,32'h12345678,1'b0});
    // data write from GNT_I: idle cycle, stray mem_ack ignored while mem_cs=0
    vq.push_back(vec_t'{1'b0,24'h000200,1'b1,1'b1,4'h3,24'h000040,32'hCAFEBABE,32'h0,1'b1,1'b0,
                        1'b0,1'b0,4'hF,24'h000200,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0});
    vq.push_back(vec_t'{1'b0,24'h000200,1'b1,1'b1,4'h3,24'h000040,32'hCAFEBABE,32'h0BADF00D,1'b1,1'b0,
                        1'b1,1'b1,4'h3,24'h000040,32'hCAFEBABE,1'b0,1'b1,32'h0BADF00D,32'h0BADF00D,1'b0});
    // contention with ack every cycle: D,I,D,I
    for (int k = 0; k < 2; k++) begin
      vq.push_back(vec_t'{1'b1,24'h000300,1'b1,1'b0,4'hF,24'h000044,32'h11111111,32'h0,1'b1,1'b0,
                          1'b1,1'b0,4'hF,24'h000044,32'h11111111,1'b0,1'b1,32'h0,32'h0,1'b0});
      vq.push_back(vec_t'{1'b1,24'h000300,1'b1,1'b0,4'hF,24'h000044,32'h11111111,32'h0,1'b1,1'b0,
                          1'b1,1'b0,4'hF,24'h000300,32'h0,1'b1,1'b0,32'h0,32'h0,1'b0});
    end
    // D idle, I requests: handover bubble
    vq.push_back(vec_t'{1'b1,24'h000500,1'b0,1'b0,4'hF,24'h000044,32'h11111111,32'h0,1'b0,1'b0,
                        1'b0,1'b0,4'hF,24'h000044,32'h11111111,1'b0,1'b0,32'h0,32'h0,1'b0});
    // I waits 3 cycles with D pending: grant must hold
    for (int k = 0; k < 3; k++)
      vq.push_back(vec_t'{1'b1,24'h000500,1'b1,1'b1,4'hC,24'h000048,32'h22222222,32'h0,1'b0,1'b0,
                          1'b1,1'b0,4'hF,24'h000500,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0});
    // ack arrives in the last watchdog cycle: genuine, not forced
    vq.push_back(vec_t'{1'b1,24'h000500,1'b1,1'b1,4'hC,24'h000048,32'h22222222,32'hA5A5A5A5,1'b1,1'b0,
                        1'b1,1'b0,4'hF,24'h000500,32'h0,1'b1,1'b0,32'hA5A5A5A5,32'hA5A5A5A5,1'b0});
    vq.push_back(vec_t'{1'b0,24'h000500,1'b1,1'b1,4'hC,24'h000048,32'h22222222,32'h0,1'b1,1'b0,
                        1'b1,1'b1,4'hC,24'h000048,32'h22222222,1'b0,1'b1,32'h0,32'h0,1'b0});
    // timeout: switch to I, then 4 cycles without ack
    vq.push_back(vec_t'{1'b1,24'h000600,1'b0,1'b1,4'hC,24'h000048,32'h22222222,32'h0,1'b0,1'b0,
                        1'b0,1'b1,4'hC,24'h000048,32'h22222222,1'b0,1'b0,32'h0,32'h0,1'b0});
    for (int k = 0; k < 3; k++)
      vq.push_back(vec_t'{1'b1,24'h000600,1'b0,1'b1,4'hC,24'h000048,32'h22222222,32'hDEADBEEF,1'b0,1'b0,
                          1'b1,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'hDEADBEEF,32'hDEADBEEF,1'b0});
    vq.push_back(vec_t'{1'b1,24'h000600,1'b0,1'b1,4'hC,24'h000048,32'h22222222,32'hDEADBEEF,1'b0,1'b0,
                        1'b1,1'b0,4'hF,24'h000600,32'h0,1'b1,1'b0,32'h0,32'hDEADBEEF,1'b0});
    // sticky flag, then clear
    vq.push_back(vec_t'{1'b0,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'h0,1'b0,1'b0,
                        1'b0,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1});
    vq.push_back(vec_t'{1'b0,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'h0,1'b0,1'b1,
                        1'b0,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1});
    vq.push_back(vec_t'{1'b0,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'h0,1'b0,1'b0,
                        1'b0,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0});
    // second timeout with err_clr in the forcing cycle: set wins
    for (int k = 0; k < 3; k++)
      vq.push_back(vec_t'{1'b1,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'hDEADBEEF,1'b0,1'b0,
                          1'b1,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'hDEADBEEF,32'hDEADBEEF,1'b0});
    vq.push_back(vec_t'{1'b1,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'hDEADBEEF,1'b0,1'b1,
                        1'b1,1'b0,4'hF,24'h000600,32'h0,1'b1,1'b0,32'h0,32'hDEADBEEF,1'b0});
    vq.push_back(vec_t'{1'b0,24'h000600,1'b0,1'b0,4'h0,24'h000048,32'h0,32'h0,1'b0,1'b0,
                        1'b0,1'b0,4'hF,24'h000600,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1});

    // ---- reset state ----
    rst_n = 1'b0;
    drive(vq[0]);
    bus.icpu_cs = 1'b1;
    bus.mem_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cs",  0, 32'(bus.mem_cs),   32'h0);
    chk("rst_iack",    0, 32'(bus.icpu_ack), 32'h0);
    chk("rst_err",     0, 32'(err_timeout),  32'h0);
    drive(vq[0]);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vq[i]);
      @(negedge clk);
      chk("mem_cs",     i, 32'(bus.mem_cs),     32'(vq[i].e_cs));
      chk("mem_we",     i, 32'(bus.mem_we),     32'(vq[i].e_we));
      chk("mem_sel",    i, 32'(bus.mem_sel),    32'(vq[i].e_sel));
      chk("mem_adr",    i, 32'(bus.mem_adr),    32'(vq[i].e_adr));
      chk("mem_dat_w",  i, bus.mem_dat_w,       vq[i].e_datw);
      chk("icpu_ack",   i, 32'(bus.icpu_ack),   32'(vq[i].e_iack));
      chk("dcpu_ack",   i, 32'(bus.dcpu_ack),   32'(vq[i].e_dack));
      chk("icpu_dat_r", i, bus.icpu_dat_r,      vq[i].e_idat);
      chk("dcpu_dat_r", i, bus.dcpu_dat_r,      vq[i].e_ddat);
      chk("err_timeout",i, 32'(err_timeout),    32'(vq[i].e_err));
    end

    // ---- reset in the middle of a data access ----
    @(posedge clk);
    #1;
    bus.icpu_cs  = 1'b0;
    bus.dcpu_cs  = 1'b1;
    bus.dcpu_we  = 1'b0;
    bus.dcpu_sel = 4'hF;
    bus.dcpu_adr = 24'h000080;
    bus.mem_ack  = 1'b0;
    @(negedge clk);
    chk("mr_bubble_cs", 0, 32'(bus.mem_cs), 32'h0);
    @(posedge clk);
    #1;
    chk("mr_d_cs",  0, 32'(bus.mem_cs),  32'h1);
    chk("mr_d_adr", 0, 32'(bus.mem_adr), 32'h000080);
    rst_n       = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    chk("mr_cs",   0, 32'(bus.mem_cs),   32'h0);
    chk("mr_iack", 0, 32'(bus.icpu_ack), 32'h0);
    chk("mr_dack", 0, 32'(bus.dcpu_ack), 32'h0);
    chk("mr_err",  0, 32'(err_timeout),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.dcpu_cs  = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.icpu_cs  = 1'b1;
    bus.icpu_adr = 24'h000700;
    #1;
    chk("mr_post_cs",  0, 32'(bus.mem_cs),  32'h1);
    chk("mr_post_adr", 0, 32'(bus.mem_adr), 32'h000700);
    chk("mr_post_sel", 0, 32'(bus.mem_sel), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
